prbs5_checker: RTL

PRBS5_CHECKER -- requirements
Module: prbs5_checker

---
 rtl/prbs5_checker.sv | 107 ++++++++++
 1 files changed

// File: rtl/prbs5_checker.sv
// PRBS5 receive checker: self-synchronises a 5-bit reference register to the incoming stream,
// then flywheels on its own prediction, flagging and counting bit errors.
module prbs5_checker #(
  parameter int LOCK_CNT = 8,
  parameter int LOSS_CNT = 3,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_in,
  input  logic             bit_valid,
  input  logic             clr_cnt,
  output logic             locked,
  output logic             bit_err,
  output logic [CNT_W-1:0] err_count,
  output logic             exp_bit
);

  typedef enum logic [1:0] {FILL, VERIFY, LOCKED} state_t;

  state_t     state;
  logic [4:0] r;
  logic [2:0] fill_cnt;
  logic [4:0] match_cnt;
  logic [2:0] miss_cnt;
  logic       pred;
  logic       hit;
  logic       miss_locked;

  assign pred        = r[1] ^ r[4];
  assign exp_bit     = pred;
  assign hit         = (bit_in == pred);
  assign miss_locked = bit_valid && (state == LOCKED) && !hit;

  // NOTE: every register below uses <= so all of them see pre-edge values of state and r.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= FILL;
      r         <= '0;
      fill_cnt  <= '0;
      match_cnt <= '0;
      miss_cnt  <= '0;
      locked    <= 1'b0;
      bit_err   <= 1'b0;
    end else begin
      bit_err <= 1'b0;
      if (bit_valid) begin
        unique case (state)
          FILL: begin
            r <= {r[3:0], bit_in};
            if (fill_cnt == 3'd4) begin
              state     <= VERIFY;
              fill_cnt  <= '0;
              match_cnt <= '0;
            end else begin
              fill_cnt <= fill_cnt + 3'd1;
            end
          end
          VERIFY: begin
            r <= {r[3:0], bit_in};
            // An all-zero register is the LFSR lock-up state and never counts towards lock.
            if (r == 5'd0 || !hit) begin
              match_cnt <= '0;
            end else if (match_cnt == 5'(LOCK_CNT - 1)) begin
              state     <= LOCKED;
              locked    <= 1'b1;
              match_cnt <= '0;
              miss_cnt  <= '0;
            end else begin
              match_cnt <= match_cnt + 5'd1;
            end
          end
          LOCKED: begin
            // Flywheel: the prediction, not the received bit, advances the reference.
            r <= {r[3:0], pred};
            if (hit) begin
              miss_cnt <= '0;
            end else begin
              bit_err <= 1'b1;
              if (miss_cnt == 3'(LOSS_CNT - 1)) begin
                state    <= FILL;
                locked   <= 1'b0;
                fill_cnt <= '0;
                miss_cnt <= '0;
              end else begin
                miss_cnt <= miss_cnt + 3'd1;
              end
            end
          end
          default: state <= FILL;
        endcase
      end
    end
  end

  // Counts the same misses that raise bit_err; the clear takes priority over an increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_count <= '0;
    end else if (clr_cnt) begin
      err_count <= '0;
    end else if (miss_locked && (err_count != '1)) begin
      err_count <= err_count + CNT_W'(1);
    end
  end

endmodule
